shift_reg_sipo: RTL and testbench

Serial-in, parallel-out deserializer: receiving end of the MSB-first serial stream produced by the team's 4-bit PISO shift register.
- Hunts for a word start marked by `sync` and shifts in `W` bits on `sdi_valid` strobes.
- Delivers each completed word through a valid/ready output register.
- Flags framing and overrun errors.

---
 rtl/sipo_pkg.sv | 16 +
 rtl/shift_reg_sipo.sv | 136 +++++++++++++
 tb/tb_shift_reg_sipo.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/sipo_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : sipo_pkg
// Description : Shared types for the serial-in, parallel-out deserializer.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
package sipo_pkg;

  // Word-framing FSM: hunting for a sync-marked MSB, or collecting bits.
  typedef enum logic [0:0] {
    HUNT  = 1'b0,
    SHIFT = 1'b1
  } sipo_state_t;

endpackage : sipo_pkg
`default_nettype wire

// File: rtl/shift_reg_sipo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : shift_reg_sipo
// Description : MSB-first serial-to-parallel deserializer. A sync-qualified
//               strobe starts a word; W strobed bits complete it. Completed
//               words are presented through a valid/ready output register,
//               with sticky overrun and framing error flags.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module shift_reg_sipo
  import sipo_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         sdi,
  input  logic         sdi_valid,
  input  logic         sync,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         overrun,
  output logic         frame_err,
  input  logic         clr_err
);

  localparam int            CW     = (W > 2) ? $clog2(W) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(W - 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  // The partial word only needs W-1 bits: the W-th bit is taken straight
  // from sdi on the completing edge.
  sipo_state_t   state_q, state_d;
  logic [W-2:0]  sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  data_q, data_d;
  logic          valid_q, valid_d;
  logic          ovr_q, ovr_d;
  logic          ferr_q, ferr_d;

  logic          w_word_done;
  logic          w_frame_set;
  logic          w_ovr_set;
  logic [W-1:0]  w_word;

  assign w_word = {sr_q, sdi};

  // Framing FSM: next state, shift register and bit counter.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    w_word_done = 1'b0;
    w_frame_set = 1'b0;
    unique case (state_q)
      HUNT: begin
        if (sdi_valid && sync) begin
          sr_d    = (W-1)'(sdi);
          cnt_d   = C_ONE;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (sdi_valid) begin
          if (sync) begin
            // Restart: current bit becomes the MSB of a fresh word.
            w_frame_set = 1'b1;
            sr_d        = (W-1)'(sdi);
            cnt_d       = C_ONE;
          end else if (cnt_q == C_LAST) begin
            w_word_done = 1'b1;
            sr_d        = '0;
            cnt_d       = '0;
            state_d     = HUNT;
          end else begin
            sr_d  = (W-1)'({sr_q, sdi});
            cnt_d = cnt_q + C_ONE;
          end
        end
      end
      default: begin
        state_d = HUNT;
        sr_d    = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Output register handshake and sticky error flags.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    w_ovr_set = 1'b0;
    if (w_word_done) begin
      if (!valid_q || out_ready) begin
        data_d  = w_word;
        valid_d = 1'b1;
      end else begin
        w_ovr_set = 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
    ovr_d  = (ovr_q  && !clr_err) || w_ovr_set;
    ferr_d = (ferr_q && !clr_err) || w_frame_set;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= HUNT;
      sr_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign overrun   = ovr_q;
  assign frame_err = ferr_q;

endmodule : shift_reg_sipo
`default_nettype wire

// File: tb/tb_shift_reg_sipo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : tb_shift_reg_sipo
// Description : Directed self-checking bench for shift_reg_sipo (W=4) with an
//               expected-word scoreboard.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_shift_reg_sipo;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       sdi;
  logic       sdi_valid;
  logic       sync;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       overrun;
  logic       frame_err;
  logic       clr_err;

  int checks   = 0;
  int failures = 0;
  logic [3:0] exp_q[$];
  logic [3:0] held;

  shift_reg_sipo #(.W(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .sdi       (sdi),
    .sdi_valid (sdi_valid),
    .sync      (sync),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun),
    .frame_err (frame_err),
    .clr_err   (clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare out_data against the oldest scoreboard entry.
  task automatic sb_check(input string tag);
    logic [3:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=%0h expected=<empty scoreboard>", tag, out_data);
    end else begin
      e = exp_q.pop_front();
      chk(tag, out_data, e);
      chk({tag, "_valid"}, out_valid, 1);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic s);
    sdi       = b;
    sync      = s;
    sdi_valid = 1'b1;
    tick();
    sdi_valid = 1'b0;
    sync      = 1'b0;
    sdi       = 1'b0;
  endtask

  // Send a sync-marked word MSB first; optionally raise out_ready only on the
  // completing edge, and insert idle cycles between strobes.
  task automatic send_word(input logic [3:0] w, input logic rdy_last, input int gap);
    for (int i = 3; i >= 0; i--) begin
      if (i == 0 && rdy_last) out_ready = 1'b1;
      send_bit(w[i], i == 3);
      out_ready = 1'b0;
      if (i != 0) repeat (gap) tick();
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; sdi = 1'b0; sdi_valid = 1'b0; sync = 1'b0;
    out_ready = 1'b0; clr_err = 1'b0;
    repeat (3) tick();
    chk("rst_data", out_data, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_frame", frame_err, 0);
    reset_n = 1'b1;
    tick();

    // Basic word 0101, held for five cycles with no consumer.
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    chk("lat_before_last", out_valid, 0);
    send_bit(1'b1, 1'b0);
    exp_q.push_back(4'b0101);
    sb_check("w0101");
    held = 4'b0101;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, held);
    end
    consume();
    chk("consume_valid", out_valid, 0);
    chk("consume_data", out_data, held);

    // Overrun: 1100 pending, 0011 dropped.
    send_word(4'b1100, 1'b0, 0);
    exp_q.push_back(4'b1100);
    sb_check("w1100");
    send_word(4'b0011, 1'b0, 0);
    chk("ovr_data", out_data, 4'b1100);
    chk("ovr_flag", overrun, 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("ovr_clr", overrun, 0);
    chk("ovr_clr_valid", out_valid, 1);

    // Consume on the same edge as completion of 1010.
    send_word(4'b1010, 1'b1, 0);
    exp_q.push_back(4'b1010);
    sb_check("w1010_same_edge");
    chk("same_edge_ovr", overrun, 0);
    consume();

    // Framing error: sync,1,1 then sync word 0110.
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    send_word(4'b0110, 1'b0, 0);
    chk("frame_flag", frame_err, 1);
    exp_q.push_back(4'b0110);
    sb_check("w0110");
    consume();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("frame_clr", frame_err, 0);

    // Bits without sync are ignored.
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("nosync_valid", out_valid, 0);

    // Gapped strobes, every third cycle, for 1001.
    send_bit(1'b1, 1'b1); tick(); tick();
    send_bit(1'b0, 1'b0); tick(); tick();
    send_bit(1'b0, 1'b0); tick(); tick();
    chk("gap_before_last", out_valid, 0);
    send_bit(1'b1, 1'b0);
    exp_q.push_back(4'b1001);
    sb_check("w1001_gapped");
    consume();

    // Mid-word asynchronous reset with pending word and both flags set.
    send_word(4'b1111, 1'b0, 0);
    send_word(4'b0000, 1'b0, 0);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b0);
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_frame", frame_err, 1);
    chk("pre_rst_ovr", overrun, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_data", out_data, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_ovr", overrun, 0);
    chk("arst_frame", frame_err, 0);
    exp_q.delete();
    tick();
    reset_n = 1'b1;
    tick();
    send_word(4'b0101, 1'b0, 0);
    exp_q.push_back(4'b0101);
    sb_check("w0101_after_rst");
    chk("after_rst_frame", frame_err, 0);
    chk("after_rst_ovr", overrun, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_shift_reg_sipo
`default_nettype wire
